// File: rtl/mem_interface_pkg.sv
// Shared constants for the memory stage: I/O window layout and instruction field positions.
`default_nettype none

package mem_interface_pkg;

    localparam int unsigned IO_BASE_DEFAULT = 32'h0000_FF00;

    typedef enum logic [1:0] {
        IO_LED = 2'd0,
        IO_SW  = 2'd1,
        IO_CNT = 2'd2
    } io_reg_e;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int EXT_HI = 7;
    localparam int EXT_LO = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 0;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

endpackage

`default_nettype wire

// File: rtl/mem_interface_mmio_regs.sv
// Memory-mapped I/O window: LED register, synchronised switches, free-running cycle counter.
`default_nettype none

module mmio_regs
    import mem_interface_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 16,
    parameter int          SW_W    = 10,
    parameter int unsigned IO_BASE = IO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [SW_W-1:0]   led_wdata,
    input  logic [SW_W-1:0]   switches,
    output logic [SW_W-1:0]   leds,
    output logic [DATA_W-1:0] io_rdata_q
);

    logic [ADDR_W-1:0] offset;
    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [15:0]       cycle_cnt;
    logic [DATA_W-1:0] io_rdata;
    logic              wr_led;
    logic              wr_cnt;

    assign offset = addr - ADDR_W'(IO_BASE);
    assign wr_led = wr_en && (offset == ADDR_W'(IO_LED));
    assign wr_cnt = wr_en && (offset == ADDR_W'(IO_CNT));

    always_comb begin
        io_rdata = '0;
        case (offset)
            ADDR_W'(IO_LED): io_rdata = DATA_W'(leds);
            ADDR_W'(IO_SW):  io_rdata = DATA_W'(sw_sync);
            ADDR_W'(IO_CNT): io_rdata = DATA_W'(cycle_cnt);
            default:         io_rdata = '0;
        endcase
    end

    // Read data is registered so it lines up with the RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            leds       <= '0;
            sw_meta    <= '0;
            sw_sync    <= '0;
            cycle_cnt  <= '0;
            io_rdata_q <= '0;
        end else begin
            sw_meta    <= switches;
            sw_sync    <= sw_meta;
            io_rdata_q <= io_rdata;
            if (wr_led) begin
                leds <= led_wdata;
            end
            if (wr_cnt) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_interface.sv
// Memory-side datapath stage: RAM address/write drive, IR/MDR capture with bypass, field decode.
`default_nettype none

module mem_interface
    import mem_interface_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 16,
    parameter int          SW_W    = 10,
    parameter int unsigned IO_BASE = IO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_s,
    input  logic              instr_en,
    input  logic              mem_reg_en,
    input  logic              mem_wr_s,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] addr_reg,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [SW_W-1:0]   switches,
    output logic [SW_W-1:0]   leds,
    output logic [3:0]        op,
    output logic [3:0]        op_ext,
    output logic [3:0]        branch_cond,
    output logic [3:0]        rdest,
    output logic [3:0]        rsrc,
    output logic [7:0]        imm,
    output logic [DATA_W-1:0] mdr
);

    logic [ADDR_W-1:0] sel_addr;
    logic              is_io;
    logic              io_q;
    logic              ir_pend;
    logic              mdr_pend;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] io_rdata_q;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dec_word;

    assign sel_addr  = mem_s ? pc : addr_reg;
    assign is_io     = (sel_addr >= ADDR_W'(IO_BASE));
    assign ram_addr  = sel_addr;
    assign ram_wdata = wdata;
    assign ram_we    = mem_wr_s & ~is_io & reset;

    mmio_regs #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SW_W    (SW_W),
        .IO_BASE (IO_BASE)
    ) u_mmio (
        .clk        (clk),
        .reset      (reset),
        .addr       (sel_addr),
        .wr_en      (mem_wr_s & is_io),
        .led_wdata  (wdata[SW_W-1:0]),
        .switches   (switches),
        .leds       (leds),
        .io_rdata_q (io_rdata_q)
    );

    assign rd_data = io_q ? io_rdata_q : ram_rdata;

    // A fetch takes priority over a load issued in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_q     <= 1'b0;
            ir_pend  <= 1'b0;
            mdr_pend <= 1'b0;
            ir_q     <= '0;
            mdr_q    <= '0;
        end else begin
            io_q     <= is_io;
            ir_pend  <= instr_en;
            mdr_pend <= mem_reg_en & ~instr_en;
            if (ir_pend) begin
                ir_q <= rd_data;
            end
            if (mdr_pend) begin
                mdr_q <= rd_data;
            end
        end
    end

    assign dec_word    = ir_pend ? rd_data : ir_q;
    assign mdr         = mdr_pend ? rd_data : mdr_q;
    assign op          = dec_word[OP_HI:OP_LO];
    assign rdest       = dec_word[RD_HI:RD_LO];
    assign branch_cond = dec_word[RD_HI:RD_LO];
    assign op_ext      = dec_word[EXT_HI:EXT_LO];
    assign rsrc        = dec_word[RS_HI:RS_LO];
    assign imm         = dec_word[IMM_HI:IMM_LO];

endmodule

`default_nettype wire

// File: tb/tb_mem_interface.sv
// Self-checking bench for mem_interface with a behavioural RAM and a reference memory/I-O model.
`default_nettype none

module tb_mem_interface;

    logic        clk;
    logic        reset;
    logic        mem_s;
    logic        instr_en;
    logic        mem_reg_en;
    logic        mem_wr_s;
    logic [15:0] pc;
    logic [15:0] addr_reg;
    logic [15:0] wdata;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic        ram_we;
    logic [15:0] ram_rdata;
    logic [9:0]  switches;
    logic [9:0]  leds;
    logic [3:0]  op;
    logic [3:0]  op_ext;
    logic [3:0]  branch_cond;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [7:0]  imm;
    logic [15:0] mdr;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [15:0] ram_wr  [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ram_next;
    logic [9:0]  m_leds;
    logic [9:0]  m_sw;
    logic [15:0] exp_ir;
    logic [15:0] exp_mdr;
    logic [27:0] dut_fields;

    mem_interface dut (
        .clk         (clk),
        .reset       (reset),
        .mem_s       (mem_s),
        .instr_en    (instr_en),
        .mem_reg_en  (mem_reg_en),
        .mem_wr_s    (mem_wr_s),
        .pc          (pc),
        .addr_reg    (addr_reg),
        .wdata       (wdata),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .switches    (switches),
        .leds        (leds),
        .op          (op),
        .op_ext      (op_ext),
        .branch_cond (branch_cond),
        .rdest       (rdest),
        .rsrc        (rsrc),
        .imm         (imm),
        .mdr         (mdr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] init_val(logic [15:0] a);
        if (a == 16'h0000) return 16'h4C25;
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Single-port synchronous RAM, read-before-write.
    always @(posedge clk) begin
        ram_next = ram_wr.exists(ram_addr) ? ram_wr[ram_addr] : init_val(ram_addr);
        if (ram_we) ram_wr[ram_addr] = ram_wdata;
        ram_rdata <= ram_next;
    end

    assign dut_fields = {op, branch_cond, rdest, op_ext, rsrc, imm};

    function automatic logic [27:0] exp_fields(logic [15:0] w);
        return {w[15:12], w[11:8], w[11:8], w[7:4], w[3:0], w[7:0]};
    endfunction

    function automatic logic [15:0] ref_rd(logic [15:0] a);
        if (a < 16'hFF00) return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        if (a == 16'hFF00) return {6'b0, m_leds};
        if (a == 16'hFF01) return {6'b0, m_sw};
        return 16'h0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_en   = 1'b0;
        mem_reg_en = 1'b0;
        mem_wr_s   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; mem_s = 1'b0; pc = '0; addr_reg = '0; wdata = '0; switches = '0;
        idle();
        step(); step();
        n_cmp++;
        if ({dut_fields, mdr, leds} !== 54'h0) begin
            n_bad++; $display("FAIL reset_state: got fields=%h mdr=%h leds=%h want 0", dut_fields, mdr, leds);
        end
        reset = 1'b1;
        step();
        instr_en = 1'b1; mem_s = 1'b1; pc = 16'h0000;
        step(); idle();
        mem_reg_en = 1'b1; mem_s = 1'b0; addr_reg = 16'h0001;
        step(); idle();
        n_cmp++;
        if (mdr !== ref_rd(16'h0001)) begin
            n_bad++; $display("FAIL reset_preload_mdr: got %h want %h", mdr, ref_rd(16'h0001));
        end
        mem_wr_s = 1'b1; addr_reg = 16'hFF00; wdata = 16'h02AA;
        step(); idle();
        instr_en = 1'b1; mem_s = 1'b1; pc = 16'h0005; mem_wr_s = 1'b1; wdata = 16'h1357;
        ref_mem[16'h0005] = 16'h1357;
        step();
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if ({dut_fields, mdr, leds, ram_we} !== 55'h0) begin
            n_bad++; $display("FAIL reset_async: got fields=%h mdr=%h leds=%h we=%b want 0", dut_fields, mdr, leds, ram_we);
        end
        idle();
        step();
        reset = 1'b1;
        step();
        n_cmp++;
        if ({dut_fields, mdr} !== 44'h0) begin
            n_bad++; $display("FAIL reset_pending_lost: got fields=%h mdr=%h want 0", dut_fields, mdr);
        end
        instr_en = 1'b1; mem_s = 1'b1; pc = 16'h0000;
        step(); idle();
        n_cmp++;
        if (dut_fields !== exp_fields(16'h4C25) || op !== 4'h4 || branch_cond !== 4'hC) begin
            n_bad++; $display("FAIL reset_first_fetch: got %h want %h", dut_fields, exp_fields(16'h4C25));
        end
        step();
        n_cmp++;
        if (dut_fields !== exp_fields(16'h4C25)) begin
            n_bad++; $display("FAIL ir_hold: got %h want %h", dut_fields, exp_fields(16'h4C25));
        end
    endtask

    task automatic test_store_load();
        mem_s = 1'b0; addr_reg = 16'h0010; wdata = 16'hBEEF; mem_wr_s = 1'b1;
        #1;
        n_cmp++;
        if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'h0010, 16'hBEEF}) begin
            n_bad++; $display("FAIL store_drive: got we=%b addr=%h wd=%h want 1 0010 beef", ram_we, ram_addr, ram_wdata);
        end
        ref_mem[16'h0010] = 16'hBEEF;
        step(); idle();
        mem_reg_en = 1'b1;
        step(); idle();
        n_cmp++;
        if (mdr !== 16'hBEEF) begin
            n_bad++; $display("FAIL store_load: got %h want beef", mdr);
        end
    endtask

    task automatic test_led_switch();
        mem_s = 1'b0; addr_reg = 16'hFF00; wdata = 16'h03FF; mem_wr_s = 1'b1;
        #1;
        n_cmp++;
        if (ram_we !== 1'b0) begin
            n_bad++; $display("FAIL led_store_we: got %b want 0", ram_we);
        end
        step(); idle();
        n_cmp++;
        if (leds !== 10'h3FF) begin
            n_bad++; $display("FAIL led_value: got %h want 3ff", leds);
        end
        switches = 10'h155;
        step(); step();
        addr_reg = 16'hFF01; mem_reg_en = 1'b1;
        step(); idle();
        n_cmp++;
        if (mdr !== 16'h0155) begin
            n_bad++; $display("FAIL switch_read: got %h want 0155", mdr);
        end
        addr_reg = 16'hFF00; mem_reg_en = 1'b1;
        step(); idle();
        n_cmp++;
        if (mdr !== 16'h03FF) begin
            n_bad++; $display("FAIL led_read: got %h want 03ff", mdr);
        end
    endtask

    task automatic test_counter();
        int c0;
        int l;
        mem_s = 1'b0; addr_reg = 16'hFF02; wdata = 16'($urandom); mem_wr_s = 1'b1;
        c0 = cyc;
        step(); idle();
        mem_reg_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            l = cyc;
            step();
            n_cmp++;
            if (mdr !== 16'(l - c0 - 1)) begin
                n_bad++; $display("FAIL cnt_clear_%0d: got %h want %h", k, mdr, 16'(l - c0 - 1));
            end
        end
        idle();
        while (cyc < c0 + 32'h0000FFFD) step();
        mem_reg_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            l = cyc;
            step();
            n_cmp++;
            if (mdr !== 16'(l - c0 - 1)) begin
                n_bad++; $display("FAIL cnt_wrap_%0d: got %h want %h", k, mdr, 16'(l - c0 - 1));
            end
        end
        idle();
    endtask

    task automatic test_simultaneous();
        mem_s = 1'b0; addr_reg = 16'h0003; mem_reg_en = 1'b1;
        step(); idle();
        mem_s = 1'b1; pc = 16'h0007; instr_en = 1'b1; mem_reg_en = 1'b1;
        step(); idle();
        n_cmp++;
        if (dut_fields !== exp_fields(ref_rd(16'h0007)) || mdr !== ref_rd(16'h0003)) begin
            n_bad++; $display("FAIL fetch_and_load: got fields=%h mdr=%h want %h %h",
                              dut_fields, mdr, exp_fields(ref_rd(16'h0007)), ref_rd(16'h0003));
        end
        step();
        n_cmp++;
        if (mdr !== ref_rd(16'h0003)) begin
            n_bad++; $display("FAIL mdr_kept: got %h want %h", mdr, ref_rd(16'h0003));
        end
        mem_s = 1'b1; pc = 16'h0008; instr_en = 1'b1; mem_wr_s = 1'b1; wdata = 16'hA5C3;
        exp_ir = ref_rd(16'h0008);
        ref_mem[16'h0008] = 16'hA5C3;
        step(); idle();
        n_cmp++;
        if (dut_fields !== exp_fields(exp_ir)) begin
            n_bad++; $display("FAIL fetch_and_store: got %h want %h", dut_fields, exp_fields(exp_ir));
        end
        mem_s = 1'b0; addr_reg = 16'h0008; mem_reg_en = 1'b1;
        step(); idle();
        n_cmp++;
        if (mdr !== 16'hA5C3) begin
            n_bad++; $display("FAIL load_after_fetch_store: got %h want a5c3", mdr);
        end
        addr_reg = 16'hFF07; mem_reg_en = 1'b1;
        step(); idle();
        n_cmp++;
        if (mdr !== 16'h0000) begin
            n_bad++; $display("FAIL unmapped_io: got %h want 0000", mdr);
        end
    endtask

    task automatic test_back_to_back();
        int kind;
        int pick;
        logic [15:0] a;
        logic [15:0] rv;
        switches = 10'($urandom); m_sw = switches;
        mem_s = 1'b0; addr_reg = 16'hFF00; wdata = 16'($urandom); mem_wr_s = 1'b1;
        m_leds = wdata[9:0];
        step(); idle();
        step(); step();
        for (int i = 0; i < 300; i++) begin
            kind = (i == 0) ? 0 : (i == 1) ? 1 : int'($urandom_range(0, 4));
            pick = int'($urandom_range(0, 39));
            if (pick < 32)       a = 16'(pick);
            else if (pick < 36)  a = 16'hFF00;
            else if (pick < 38)  a = 16'hFF01;
            else                 a = 16'hFF05;
            mem_s      = 1'($urandom_range(0, 1));
            pc         = mem_s ? a : 16'($urandom);
            addr_reg   = mem_s ? 16'($urandom) : a;
            instr_en   = (kind == 0 || kind == 3 || kind == 4);
            mem_reg_en = (kind == 1 || kind == 3);
            mem_wr_s   = (kind == 2 || kind == 4);
            wdata      = 16'($urandom);
            #1;
            n_cmp++;
            if (ram_addr !== a || ram_we !== (mem_wr_s && a < 16'hFF00)) begin
                n_bad++; $display("FAIL rand_drive_%0d: got addr=%h we=%b want %h %b",
                                  i, ram_addr, ram_we, a, mem_wr_s && a < 16'hFF00);
            end
            rv = ref_rd(a);
            if (instr_en) exp_ir = rv;
            else if (mem_reg_en) exp_mdr = rv;
            if (mem_wr_s) begin
                if (a < 16'hFF00) ref_mem[a] = wdata;
                else if (a == 16'hFF00) m_leds = wdata[9:0];
            end
            step();
            if (i >= 1) begin
                n_cmp++;
                if (dut_fields !== exp_fields(exp_ir) || mdr !== exp_mdr || leds !== m_leds) begin
                    n_bad++; $display("FAIL rand_out_%0d: got fields=%h mdr=%h leds=%h want %h %h %h",
                                      i, dut_fields, mdr, leds, exp_fields(exp_ir), exp_mdr, m_leds);
                end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_led_switch();
        test_counter();
        test_simultaneous();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
